// File: rtl/writeback_regfile_pkg.sv
// -----------------------------------------------------------------------------
// writeback_regfile_pkg
//   Shared constants and types for the writeback stage and its register file.
//   - DATA_W    : architectural register / data width
//   - reg_idx_t : 5-bit register index
//   - REG_ZERO / REG_SP / REG_RA : well-known MIPS register indices
// -----------------------------------------------------------------------------
package writeback_regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/writeback_regfile_core.sv
// -----------------------------------------------------------------------------
// regfile_core
//   32-entry architectural register file: one synchronous write port and
//   NREAD combinational read ports with hard-wired zero and same-cycle
//   write-to-read bypass.
//
//   Ports:
//     Clk        in   clock, writes on posedge
//     Reset      in   asynchronous active-high; clears all entries, $sp <= SP_RESET
//     WriteEn    in   write request (register 0 is filtered here)
//     WriteAddr  in   [4:0] destination index
//     WriteData  in   [DATA_W-1:0] data to write
//     ReadAddr   in   [NREAD*5-1:0] packed read indices, port p at [p*5 +: 5]
//     ReadData   out  [NREAD*DATA_W-1:0] packed read data, port p at [p*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module regfile_core #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = '0,
    parameter int                NREAD    = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    WriteEn,
    input  logic [4:0]              WriteAddr,
    input  logic [DATA_W-1:0]       WriteData,
    input  logic [NREAD*5-1:0]      ReadAddr,
    output logic [NREAD*DATA_W-1:0] ReadData
);
    import writeback_regfile_pkg::*;

    logic [DATA_W-1:0] regs [32];
    logic              wrEff;

    // A write held off by Reset must not be visible through the bypass either,
    // otherwise a read during reset would show data that is never committed.
    assign wrEff = WriteEn && !Reset && (WriteAddr != REG_ZERO);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (reg_idx_t'(i) == REG_SP) ? SP_RESET : '0;
            end
        end else if (wrEff) begin
            regs[WriteAddr] <= WriteData;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [4:0] addr;
        assign addr = ReadAddr[p*5 +: 5];
        assign ReadData[p*DATA_W +: DATA_W] =
            (addr == REG_ZERO)                ? '0        :
            (wrEff && (addr == WriteAddr))    ? WriteData :
                                                regs[addr];
    end

endmodule

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//   Writeback stage of the 5-stage MIPS pipeline plus the architectural
//   register file. Selects the writeback result from the MEM/WB outputs,
//   commits it, serves the decode read ports (with bypass), holds the display
//   latch and counts committed register writes.
//
//   Optional build macro: WB_DEBUG_PORT_EN adds DbgRegAddr/DbgRegData, a third
//   read port for the board register viewer.
//
//   Ports:
//     Clk, Reset                      clock, async active-high reset
//     RegWriteW, MemtoRegW, jalW      MEM/WB control
//     DisplayW                        capture ResultW into DisplayOut
//     WriteRegW                       destination index
//     MemReadDataW, ALUResultW,
//     PCPlus4W                        writeback data candidates
//     ReadReg1D, ReadReg2D            decode read indices
//     ReadData1D, ReadData2D          decode read data (combinational)
//     ResultW                         selected writeback value (combinational)
//     DisplayOut                      registered display value
//     WriteCount                      committed register-write counter
//     DbgRegAddr, DbgRegData          debug read port (WB_DEBUG_PORT_EN only)
// -----------------------------------------------------------------------------
module writeback_regfile #(
    parameter int                DATA_W   = writeback_regfile_pkg::DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = '0,
    parameter int                RA_REG   = int'(writeback_regfile_pkg::REG_RA)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic              jalW,
    input  logic              DisplayW,
    input  logic [4:0]        WriteRegW,
    input  logic [DATA_W-1:0] MemReadDataW,
    input  logic [DATA_W-1:0] ALUResultW,
    input  logic [DATA_W-1:0] PCPlus4W,
    input  logic [4:0]        ReadReg1D,
    input  logic [4:0]        ReadReg2D,
`ifdef WB_DEBUG_PORT_EN
    input  logic [4:0]        DbgRegAddr,
    output logic [DATA_W-1:0] DbgRegData,
`endif
    output logic [DATA_W-1:0] ReadData1D,
    output logic [DATA_W-1:0] ReadData2D,
    output logic [DATA_W-1:0] ResultW,
    output logic [DATA_W-1:0] DisplayOut,
    output logic [31:0]       WriteCount
);
    import writeback_regfile_pkg::*;

`ifdef WB_DEBUG_PORT_EN
    localparam int NREAD = 3;
`else
    localparam int NREAD = 2;
`endif

    reg_idx_t                destW;
    logic                    weW;
    logic [DATA_W-1:0]       displayQ;
    logic [31:0]             writeCountQ;
    logic [NREAD*5-1:0]      rdAddr;
    logic [NREAD*DATA_W-1:0] rdData;

    // Priority select; the ternary chain keeps unselected inputs (possibly X)
    // off ResultW.
    assign ResultW = jalW      ? PCPlus4W     :
                     MemtoRegW ? MemReadDataW :
                                 ALUResultW;

    assign destW = jalW ? reg_idx_t'(RA_REG) : WriteRegW;

    // jal commits its return address regardless of RegWriteW.
    assign weW = (RegWriteW || jalW) && (destW != REG_ZERO);

`ifdef WB_DEBUG_PORT_EN
    assign rdAddr     = {DbgRegAddr, ReadReg2D, ReadReg1D};
    assign DbgRegData = rdData[2*DATA_W +: DATA_W];
`else
    assign rdAddr     = {ReadReg2D, ReadReg1D};
`endif

    assign ReadData1D = rdData[0      +: DATA_W];
    assign ReadData2D = rdData[DATA_W +: DATA_W];

    regfile_core #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET),
        .NREAD    (NREAD)
    ) u_core (
        .Clk       (Clk),
        .Reset     (Reset),
        .WriteEn   (weW),
        .WriteAddr (destW),
        .WriteData (ResultW),
        .ReadAddr  (rdAddr),
        .ReadData  (rdData)
    );

    // Display latch captures even writes aimed at register 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            displayQ <= '0;
        end else if (DisplayW) begin
            displayQ <= ResultW;
        end
    end

    // Free-running 32-bit counter; natural wrap at 2^32.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            writeCountQ <= '0;
        end else if (weW) begin
            writeCountQ <= writeCountQ + 32'd1;
        end
    end

    assign DisplayOut = displayQ;
    assign WriteCount = writeCountQ;

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
//   Self-checking bench: directed scenarios plus randomized traffic, compared
//   every cycle against an array-based model of the register file.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;

    localparam logic [31:0] SP = 32'h7FFF_FFFC;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RegWriteW, MemtoRegW, jalW, DisplayW;
    logic [4:0]  WriteRegW, ReadReg1D, ReadReg2D;
    logic [31:0] MemReadDataW, ALUResultW, PCPlus4W;
    logic [31:0] ReadData1D, ReadData2D, ResultW, DisplayOut, WriteCount;

    writeback_regfile #(
        .DATA_W   (32),
        .SP_RESET (SP),
        .RA_REG   (31)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .jalW         (jalW),
        .DisplayW     (DisplayW),
        .WriteRegW    (WriteRegW),
        .MemReadDataW (MemReadDataW),
        .ALUResultW   (ALUResultW),
        .PCPlus4W     (PCPlus4W),
        .ReadReg1D    (ReadReg1D),
        .ReadReg2D    (ReadReg2D),
        .ReadData1D   (ReadData1D),
        .ReadData2D   (ReadData2D),
        .ResultW      (ResultW),
        .DisplayOut   (DisplayOut),
        .WriteCount   (WriteCount)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    logic [31:0] mReg [32];
    logic [31:0] mCount;
    logic [31:0] mDisp;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mResult();
        if (jalW)      return PCPlus4W;
        if (MemtoRegW) return MemReadDataW;
        return ALUResultW;
    endfunction

    function automatic logic [4:0] mDest();
        return jalW ? 5'd31 : WriteRegW;
    endfunction

    function automatic logic mWe();
        return !Reset && (RegWriteW || jalW) && (mDest() != 5'd0);
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (mWe() && a == mDest()) return mResult();
        return mReg[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("ResultW",    ResultW,    mResult());
        chk("ReadData1D", ReadData1D, mRead(ReadReg1D));
        chk("ReadData2D", ReadData2D, mRead(ReadReg2D));
        chk("DisplayOut", DisplayOut, mDisp);
        chk("WriteCount", WriteCount, mCount);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
        mReg[29] = SP;
        mCount   = 32'd0;
        mDisp    = 32'd0;
    endtask

    task automatic model_commit();
        logic [31:0] r;
        logic [4:0]  d;
        logic        we;
        r  = mResult();
        d  = mDest();
        we = mWe();
        if (!Reset) begin
            if (we) begin
                mReg[d] = r;
                mCount  = mCount + 32'd1;
            end
            if (DisplayW) mDisp = r;
        end
    endtask

    // Check combinational/registered outputs mid-cycle, then advance one edge.
    task automatic half_a();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic half_b();
        @(posedge Clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        RegWriteW = 1'b0;
        jalW      = 1'b0;
        DisplayW  = 1'b0;
        MemtoRegW = 1'b0;
    endtask

    task automatic rand_inputs();
        RegWriteW    = ($urandom_range(0, 3) != 0);
        MemtoRegW    = 1'($urandom);
        jalW         = ($urandom_range(0, 7) == 0);
        DisplayW     = ($urandom_range(0, 3) == 0);
        WriteRegW    = 5'($urandom);
        MemReadDataW = $urandom;
        ALUResultW   = $urandom;
        PCPlus4W     = $urandom;
        ReadReg1D    = ($urandom_range(0, 3) == 0) ? (jalW ? 5'd31 : WriteRegW) : 5'($urandom);
        ReadReg2D    = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom);
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        WriteRegW = 5'd0; ReadReg1D = 5'd0; ReadReg2D = 5'd29;
        MemReadDataW = 32'd0; ALUResultW = 32'd0; PCPlus4W = 32'd0;
        model_reset();
        half_a(); half_b();
        half_a(); half_b();
        Reset = 1'b0;

        // Warm-up so the counter and display hold non-zero values
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            half_a(); half_b();
        end

        // Reset asserted mid-write takes effect immediately
        RegWriteW = 1'b1; MemtoRegW = 1'b0; jalW = 1'b0; DisplayW = 1'b1;
        WriteRegW = 5'd5; ALUResultW = 32'h0000_DEAD;
        ReadReg1D = 5'd5; ReadReg2D = 5'd29;
        half_a();
        #2 Reset = 1'b1;
        model_reset();
        #1;
        chk("rst_count",   WriteCount, 32'd0);
        chk("rst_display", DisplayOut, 32'd0);
        chk("rst_reg5",    ReadData1D, 32'd0);
        chk("rst_sp",      ReadData2D, 32'h7FFF_FFFC);
        half_b();
        idle();
        Reset = 1'b0;
        half_a();
        chk("post_rst_reg5", ReadData1D, 32'd0);
        chk("post_rst_sp",   ReadData2D, 32'h7FFF_FFFC);
        half_b();

        // Load writeback with same-cycle bypass
        RegWriteW = 1'b1; MemtoRegW = 1'b1; WriteRegW = 5'd8;
        MemReadDataW = 32'h0000_1234; ALUResultW = 32'h0000_9999;
        ReadReg1D = 5'd8; ReadReg2D = 5'd0;
        half_a();
        chk("load_bypass", ReadData1D, 32'h0000_1234);
        chk("load_result", ResultW,    32'h0000_1234);
        half_b();
        idle();
        half_a();
        chk("load_reg8",  ReadData1D, 32'h0000_1234);
        chk("load_count", WriteCount, 32'd1);
        half_b();

        // jal commits to $ra without RegWriteW
        jalW = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b1; WriteRegW = 5'd3;
        PCPlus4W = 32'h0040_0010; ReadReg1D = 5'd31; ReadReg2D = 5'd3;
        half_a();
        chk("jal_bypass", ReadData1D, 32'h0040_0010);
        chk("jal_reg3",   ReadData2D, 32'd0);
        half_b();
        idle();
        half_a();
        chk("jal_reg31",  ReadData1D, 32'h0040_0010);
        chk("jal_reg3b",  ReadData2D, 32'd0);
        chk("jal_count",  WriteCount, 32'd2);
        half_b();

        // Write to register 0 is dropped but still reaches the display
        RegWriteW = 1'b1; MemtoRegW = 1'b0; WriteRegW = 5'd0; DisplayW = 1'b1;
        ALUResultW = 32'hFFFF_FFFF; ReadReg1D = 5'd0; ReadReg2D = 5'd0;
        half_a();
        chk("r0_rd1",    ReadData1D, 32'd0);
        chk("r0_rd2",    ReadData2D, 32'd0);
        chk("r0_result", ResultW,    32'hFFFF_FFFF);
        half_b();
        idle();
        half_a();
        chk("r0_count",   WriteCount, 32'd2);
        chk("r0_display", DisplayOut, 32'hFFFF_FFFF);
        half_b();

        // Both ports bypass the same register
        RegWriteW = 1'b1; WriteRegW = 5'd17; ALUResultW = 32'h0000_0055;
        ReadReg1D = 5'd17; ReadReg2D = 5'd17;
        half_a();
        chk("dual_byp1", ReadData1D, 32'h0000_0055);
        chk("dual_byp2", ReadData2D, 32'h0000_0055);
        half_b();
        idle();
        half_a();
        chk("dual_reg1",  ReadData1D, 32'h0000_0055);
        chk("dual_reg2",  ReadData2D, 32'h0000_0055);
        chk("dual_count", WriteCount, 32'd3);
        half_b();

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            half_a();
            if (i == 200) begin
                #2 Reset = 1'b1;
                model_reset();
                #1 compare_all();
            end
            half_b();
            Reset = 1'b0;
        end

        // Counter wrap, starting from a forced near-full value
        idle();
        force dut.writeCountQ = 32'hFFFF_FFFE;
        #1 release dut.writeCountQ;
        mCount = 32'hFFFF_FFFE;
        RegWriteW = 1'b1; WriteRegW = 5'd9; ALUResultW = 32'h0BAD_F00D;
        ReadReg1D = 5'd9; ReadReg2D = 5'd1;
        half_a(); half_b();
        half_a();
        chk("wrap_full", WriteCount, 32'hFFFF_FFFF);
        half_b();
        idle();
        half_a();
        chk("wrap_zero", WriteCount, 32'd0);
        half_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
